// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit controller
// UART_TX_PARITY_EN selects the even-parity frame bit.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int DATA_W_DEF       = 8;
  localparam int BIT_CNT_W        = 4;

`ifdef UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE   = 3'd0;
  localparam tx_state_t ST_START  = 3'd1;
  localparam tx_state_t ST_DATA   = 3'd2;
  localparam tx_state_t ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam tx_state_t ST_PARITY = 3'd4;
`endif

  function automatic int frame_bits(input int data_w, input int stop_bits);
    return 1 + data_w + PARITY_BITS + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-time counter producing a one-cycle tick on its terminal count
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear || bit_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit FSM, shift register and registered line select
// UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_out
);

  tx_state_t             state_q, state_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  tx_out_q, line_d;
  logic                  bit_tick;
  logic                  done_d;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  // Counter is held at zero whenever idle so each frame starts on a clean bit time.
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q == ST_IDLE),
    .bit_tick (bit_tick)
  );

  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = ~tx_ready;
  assign tx_done  = done_d;
  assign tx_out   = tx_out_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          shift_d   = tx_data;
          bit_cnt_d = '0;
          state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d     = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_tick) begin
          if (bit_cnt_q == BIT_CNT_W'(STOP_BITS - 1)) begin
            done_d    = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    line_d = 1'b1;
    case (state_q)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: line_d = par_q;
`endif
      default:   line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_out_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_out_q  <= line_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller: accepts a parallel byte over a valid/ready handshake and sequences start, data, optional parity and stop bits onto the serial line at a fixed baud rate. It owns the baud-tick counter, bit counter, frame shift register and the idle/data line select, so the transmit path needs no further sequencing logic. It sits between the host-side byte source and the TX pin.

## Interface
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range ≥1
- DATA_W, 8, data bits per frame; legal range 5–9
- STOP_BITS, 1, number of stop bits; 1 or 2
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- tx_valid  in  1  host has a byte on tx_data
- tx_data  in  DATA_W  byte to send, LSB transmitted first
- tx_ready  out  1  controller can accept; high only in IDLE
- tx_busy  out  1  frame in progress; equals !tx_ready
- tx_done  out  1  one-cycle pulse at end of last stop bit
- tx_out  out  1  serial line, registered; idle level 1

## Operation
- States: IDLE, START, DATA, PARITY (present only with macro), STOP.
- Reset: state=IDLE, tx_out=1, tx_done=0, baud and bit counters=0, shift register=0; tx_ready=1 from the first cycle after reset deasserts.
- IDLE: line select forces tx_out=1. On tx_valid && tx_ready, capture tx_data into the shift register, clear the baud counter, go to START.
- START: tx_out=0 for CLKS_PER_BIT cycles.
- DATA: line select routes the shift register LSB to tx_out; after each CLKS_PER_BIT cycles shift right by one; bit counter runs 0..DATA_W-1, then goes to PARITY or STOP.
- PARITY: tx_out = even parity (XOR of captured data) for one bit time.
- STOP: tx_out=1 for STOP_BITS bit times; in the final cycle of the last stop bit assert tx_done and go to IDLE.
- tx_valid outside IDLE is ignored; tx_data changes after capture do not affect the frame.
- Baud counter: width $clog2(CLKS_PER_BIT+1); counts 0..CLKS_PER_BIT-1, a bit boundary occurs on its terminal count, it wraps to 0. CLKS_PER_BIT=1 means every cycle is a boundary.
- Reset asserted mid-frame aborts immediately: next edge restores the reset values, with no tx_done and no partial stop bit.

## Timing
- Handshake at edge E: tx_out goes to 0 at edge E+1 (registered output).
- Each bit holds exactly CLKS_PER_BIT cycles.
- Frame length from E+1: (1 + DATA_W + P + STOP_BITS) × CLKS_PER_BIT cycles, where P=1 with parity, else 0.
- tx_done is high in the last cycle of the final stop bit. tx_ready rises on the next cycle.
- Back-to-back: if tx_valid is held, the next start bit begins one cycle after tx_ready rises. There is exactly one idle-high cycle between frames.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state and its bit are compiled in; even parity; frame grows by one bit.
- Not defined: the PARITY state does not exist; DATA goes directly to STOP.

## Structure
- Package uart_pkg: state enum type tx_state_t; constant defaults for CLKS_PER_BIT and DATA_W; localparam for the parity bit count.
- One sub-module, uart_baud_gen: the baud counter with a clear input and a one-cycle bit_tick output. The FSM, shift register and line select stay in uart_tx_ctrl.

## Test plan
All scenarios use CLKS_PER_BIT=4, DATA_W=8, STOP_BITS=1.
- Reset then idle: tx_out=1, tx_ready=1, tx_done=0 held for 50 cycles.
- Send 0xA5, no parity: tx_out sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. tx_done pulses at cycle 40 after capture. With UART_TX_PARITY_EN, the parity bit is 0 and the frame is 44 cycles.
- Hold tx_valid with 0x0F then 0xF0: two complete frames separated by exactly one idle-high cycle. The second frame's data is 0xF0.
- Change tx_data and pulse tx_valid during the DATA state of a 0x3C frame: the line still carries 0x3C, and the second request is not accepted (tx_ready=0).
- Assert reset for one cycle at bit 3 of a 0xFF frame: the next cycle shows tx_out=1 and tx_ready=1. No tx_done occurs, and the following frame transmits correctly.
- CLKS_PER_BIT=1, send 0x01: each bit lasts one cycle and the frame is 10 cycles.
